// File: rtl/vga_frame_fetch.sv
// vga_frame_fetch: programmable VGA timing with an upscaled, placeable
// framebuffer window. The read address is issued on the counter cycle; sync,
// blank, window and tile flags follow through a MEM_LAT-deep delay line so
// they meet the returning pixel. One output register stage follows.
module vga_frame_fetch #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned IMG_W      = 256,
  parameter int unsigned IMG_H      = 240,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned X0         = 64,
  parameter int unsigned Y0         = 0,
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned MEM_LAT    = 2
) (
  input  logic              clock_25,
  input  logic              reset,
  input  logic              start,
  input  logic              src_sel,
  input  logic              hl_en,
  input  logic [3:0]        quadrant,
  input  logic [7:0]        data_drom,
  input  logic [7:0]        data_dram,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              n_blank,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned WIN_W   = IMG_W << SCALE_LOG2;
  localparam int unsigned WIN_H   = IMG_H << SCALE_LOG2;
  localparam int unsigned TILE_W  = WIN_W >> 2;
  localparam int unsigned TILE_H  = WIN_H >> 2;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned SW      = (SCALE_LOG2 == 0) ? 1 : SCALE_LOG2;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_LO     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_HI     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_LO     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_HI     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] WX_FIRST  = HW'(X0);
  localparam logic [HW-1:0] WX_LAST   = HW'(X0 + WIN_W - 1);
  localparam logic [VW-1:0] WY_FIRST  = VW'(Y0);
  localparam logic [HW-1:0] WIN_W_C   = HW'(WIN_W);
  localparam logic [VW-1:0] WIN_H_C   = VW'(WIN_H);
  localparam logic [HW-1:0] TX1       = HW'(TILE_W);
  localparam logic [HW-1:0] TX2       = HW'(2 * TILE_W);
  localparam logic [HW-1:0] TX3       = HW'(3 * TILE_W);
  localparam logic [VW-1:0] TY1       = VW'(TILE_H);
  localparam logic [VW-1:0] TY2       = VW'(2 * TILE_H);
  localparam logic [VW-1:0] TY3       = VW'(3 * TILE_H);
  localparam logic [SW-1:0] SUB_MAX   = SW'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // delay-line bit layout: {src_sel, tile_hit, in_win, n_blank, vsync, hsync}
  localparam logic [5:0] DL_RST = 6'b00_0011;

  if ((X0 + WIN_W > H_ACTIVE) || (Y0 + WIN_H > V_ACTIVE)) begin : g_win_check
    $fatal(1, "vga_frame_fetch: image window exceeds the active area");
  end
  if ((MEM_LAT < 1) || (MEM_LAT > 4)) begin : g_lat_check
    $fatal(1, "vga_frame_fetch: MEM_LAT must be 1..4");
  end

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic              frame_start_q;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [SW-1:0]     hsub_q, hsub_d;
  logic [SW-1:0]     vsub_q, vsub_d;
  logic [5:0]        dl_q [MEM_LAT];
  logic [5:0]        stage_c, tap_c;
  logic [7:0]        red_q, green_q, blue_q, pix_c;
  logic              hsync_q, vsync_q, n_blank_q;
  logic              win_c, win_n, fs_n, video_c;
  logic [HW-1:0]     wx_c;
  logic [VW-1:0]     wy_c;
  logic [1:0]        tx_c, ty_c;

  // Offsets wrap to large values left/above the window, so one compare each suffices.
  function automatic logic in_window(input logic [HW-1:0] h, input logic [VW-1:0] v);
    logic [HW-1:0] ox;
    logic [VW-1:0] oy;
    ox = h - WX_FIRST;
    oy = v - WY_FIRST;
    return (ox < WIN_W_C) && (oy < WIN_H_C);
  endfunction

  // next raster position
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  assign win_c = in_window(h_q, v_q);
  assign win_n = in_window(h_d, v_d);
  assign fs_n  = (h_d == '0) && (v_d == '0);
  assign wx_c  = h_q - WX_FIRST;
  assign wy_c  = v_q - WY_FIRST;
  assign tx_c  = (wx_c >= TX3) ? 2'd3 : (wx_c >= TX2) ? 2'd2 : (wx_c >= TX1) ? 2'd1 : 2'd0;
  assign ty_c  = (wy_c >= TY3) ? 2'd3 : (wy_c >= TY2) ? 2'd2 : (wy_c >= TY1) ? 2'd1 : 2'd0;

  // raster counters and undelayed frame-start pulse
  always_ff @(posedge clock_25) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= fs_n;
    end
  end

  // Incremental address for the next position; it is held through the right
  // margin and only rewound to row_base on entry to the next window row.
  always_comb begin
    addr_d     = addr_q;
    row_base_d = row_base_q;
    hsub_d     = hsub_q;
    vsub_d     = vsub_q;
    if (win_c && (h_q == WX_LAST)) begin
      if (vsub_q == SUB_MAX) begin
        vsub_d     = '0;
        row_base_d = row_base_q + ROW_STEP;
      end else begin
        vsub_d = vsub_q + 1'b1;
      end
    end
    if (fs_n) begin
      addr_d     = '0;
      row_base_d = '0;
      hsub_d     = '0;
      vsub_d     = '0;
    end else if (win_n) begin
      if (h_d == WX_FIRST) begin
        addr_d = row_base_q;
        hsub_d = '0;
      end else if (hsub_q == SUB_MAX) begin
        addr_d = addr_q + 1'b1;
        hsub_d = '0;
      end else begin
        hsub_d = hsub_q + 1'b1;
      end
    end
  end

  // address generator state
  always_ff @(posedge clock_25) begin
    if (reset) begin
      addr_q     <= '0;
      row_base_q <= '0;
      hsub_q     <= '0;
      vsub_q     <= '0;
    end else begin
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      hsub_q     <= hsub_d;
      vsub_q     <= vsub_d;
    end
  end

  // display arming: start arms, the next frame boundary starts output
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_ARM;
      ST_ARM:  if (frame_start_q) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock_25) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign stage_c = {src_sel,
                    hl_en && win_c && ({ty_c, tx_c} == quadrant),
                    win_c,
                    (h_q < H_ACT_C) && (v_q < V_ACT_C),
                    !((v_q >= VS_LO) && (v_q < VS_HI)),
                    !((h_q >= HS_LO) && (h_q < HS_HI))};

  // control flags follow the memory read latency
  always_ff @(posedge clock_25) begin
    if (reset) begin
      for (int unsigned i = 0; i < MEM_LAT; i++) dl_q[i] <= DL_RST;
    end else begin
      dl_q[0] <= stage_c;
      for (int unsigned i = 1; i < MEM_LAT; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign tap_c   = dl_q[MEM_LAT-1];
  assign pix_c   = tap_c[5] ? data_dram : data_drom;
  assign video_c = (state_q == ST_RUN) && tap_c[3] && tap_c[2];

  // registered video outputs
  always_ff @(posedge clock_25) begin
    if (reset) begin
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      n_blank_q <= 1'b0;
    end else begin
      red_q     <= video_c ? (tap_c[4] ? 8'hFF : pix_c) : '0;
      green_q   <= video_c ? pix_c : '0;
      blue_q    <= video_c ? pix_c : '0;
      hsync_q   <= tap_c[0];
      vsync_q   <= tap_c[1];
      n_blank_q <= tap_c[2];
    end
  end

  assign address     = addr_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign n_blank     = n_blank_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Directed bench for vga_frame_fetch on a reduced raster (80x55 total,
// 64x48 active) so several frames fit in a short run. Window: 16x12 source
// scaled x2 at (16,8) -> h in [16,48), v in [8,32); tiles 8x6 screen pixels.
// Memory model: 2-cycle latency, ROM data = address[7:0] + 1, RAM data = 8'h55.
module tb_vga_frame_fetch;

  localparam int HT = 80;
  localparam int FT = 80 * 55;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        src_sel = 1'b0;
  logic        hl_en = 1'b0;
  logic [3:0]  quadrant = 4'd0;
  logic [7:0]  data_drom, data_dram;
  logic [17:0] address;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, n_blank, frame_start;
  logic [17:0] a1 = '0, a2 = '0;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  vga_frame_fetch #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .IMG_W(16), .IMG_H(12), .SCALE_LOG2(1), .X0(16), .Y0(8),
    .ADDR_W(18), .MEM_LAT(2)
  ) dut (
    .clock_25(clk), .reset(reset), .start(start), .src_sel(src_sel),
    .hl_en(hl_en), .quadrant(quadrant), .data_drom(data_drom),
    .data_dram(data_dram), .address(address), .red(red), .green(green),
    .blue(blue), .hsync(hsync), .vsync(vsync), .n_blank(n_blank),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    a1 <= address;
    a2 <= a1;
  end
  assign data_drom = a2[7:0] + 8'd1;
  assign data_dram = 8'h55;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // advance to raster position (h,v), possibly in the following frame
  task automatic go_to(input int h, input int v);
    int d;
    d = ((v * HT + h) - (cyc % FT) + FT) % FT;
    repeat (d) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(address), 0);
    chk({tag, "_rgb"}, {8'h0, red, green, blue}, 0);
    chk({tag, "_hs"}, 32'(hsync), 1);
    chk({tag, "_vs"}, 32'(vsync), 1);
    chk({tag, "_nb"}, 32'(n_blank), 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
  endtask

  initial begin
    repeat (3) step();
    chk_reset_vals("rst");
    reset = 1'b0;
    cyc = 0;

    // frame 0, idle: timing, address walk, RGB forced to zero
    chk("fs_after_rst", 32'(frame_start), 0);
    go_to(66, 0);  chk("nb_h63", 32'(n_blank), 1);
    go_to(67, 0);  chk("nb_h64", 32'(n_blank), 0);
    go_to(70, 0);  chk("hs_h67", 32'(hsync), 1);
    go_to(71, 0);  chk("hs_h68", 32'(hsync), 0);
    go_to(78, 0);  chk("hs_h75", 32'(hsync), 0);
    go_to(79, 0);  chk("hs_h76", 32'(hsync), 1);
    go_to(16, 8);  chk("addr_16_8", 32'(address), 0);
    go_to(18, 8);  chk("addr_18_8", 32'(address), 1);
    go_to(21, 8);  chk("rgb_idle", {8'h0, red, green, blue}, 0);
    go_to(46, 8);  chk("addr_46_8", 32'(address), 15);
    go_to(48, 8);  chk("addr_48_8", 32'(address), 15);
    go_to(60, 8);  chk("addr_60_8", 32'(address), 15);
    go_to(16, 9);  chk("addr_16_9", 32'(address), 0);
    go_to(16, 10); chk("addr_16_10", 32'(address), 16);
    go_to(0, 20);
    start = 1'b1; step(); start = 1'b0;
    go_to(21, 24); chk("rgb_armed", {8'h0, red, green, blue}, 0);
    go_to(46, 31); chk("addr_46_31", 32'(address), 191);
    go_to(10, 40); chk("addr_hold", 32'(address), 191);
    go_to(2, 50);  chk("vs_v49", 32'(vsync), 1);
    go_to(3, 50);  chk("vs_v50", 32'(vsync), 0);
    go_to(3, 52);  chk("vs_v52", 32'(vsync), 1);
    go_to(79, 54); chk("fs_last", 32'(frame_start), 0);

    // frame 1, running
    go_to(0, 0);   chk("fs_period", 32'(frame_start), 1);
                   chk("addr_0_0", 32'(address), 0);
    go_to(1, 0);   chk("fs_pulse", 32'(frame_start), 0);
    hl_en = 1'b1; quadrant = 4'd5;
    go_to(5, 0);
    start = 1'b1; step(); start = 1'b0;
    go_to(18, 8);  chk("red_h15", 32'(red), 0);
                   chk("nb_h15", 32'(n_blank), 1);
    go_to(19, 8);  chk("red_h16", 32'(red), 8'h01);
    go_to(21, 8);  chk("rgb_h18", {8'h0, red, green, blue}, 32'h020202);
                   chk("nb_h18", 32'(n_blank), 1);
                   chk("hs_h18", 32'(hsync), 1);
    go_to(50, 8);  chk("blue_h47", 32'(blue), 8'h10);
    go_to(51, 8);  chk("blue_h48", 32'(blue), 0);
    go_to(26, 14); chk("red_t4", 32'(red), 8'h34);
    go_to(27, 14); chk("red_t5", 32'(red), 8'hFF);
                   chk("green_t5", 32'(green), 8'h35);
    go_to(34, 19); chk("red_t5_end", 32'(red), 8'hFF);
                   chk("blue_t5_end", 32'(blue), 8'h58);
    go_to(35, 19); chk("red_t6", 32'(red), 8'h59);
    go_to(0, 20);
    hl_en = 1'b0; quadrant = 4'd9;
    go_to(27, 20); chk("red_hl_off", 32'(red), 8'h65);
    go_to(0, 22);
    src_sel = 1'b1;
    go_to(33, 24); chk("rgb_ram", {8'h0, red, green, blue}, 32'h555555);
    go_to(40, 28); chk("red_pre_rst", 32'(red), 8'h55);

    // reset mid-frame while running
    reset = 1'b1; step();
    chk_reset_vals("rst_mid");
    reset = 1'b0; src_sel = 1'b0;
    cyc = 0;
    go_to(18, 8);  chk("addr_post_rst", 32'(address), 1);
    go_to(21, 8);  chk("rgb_post_rst", {8'h0, red, green, blue}, 0);
    go_to(0, 0);   chk("fs_post_rst", 32'(frame_start), 1);
    go_to(21, 8);  chk("rgb_idle_f1", {8'h0, red, green, blue}, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
